// File: rtl/inv_trans_divider.sv
// inv_trans_divider
//   Iterative reciprocal unit producing the Q2.14 inverse transmission 1/t for
//   the scene-recovery multiplier. Each transaction takes one Q1.15 sample t,
//   clamps it to [T_MIN, 1.0], and computes floor(2^29 / t) with a radix-2
//   restoring divider, one quotient bit per clock. The result is saturated to
//   16 bits and returned over a valid/ready handshake.
//
//   Optional build macro: INV_TRANS_ROUND_EN
//     defined   : dividend = 2^29 + (d >> 1), round-to-nearest (ties up)
//     undefined : dividend = 2^29, truncation
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   in_valid   in   trans_in is valid
//   in_ready   out  block can accept a new sample
//   trans_in   in   [15:0] transmission t, unsigned Q1.15 (32768 = 1.0)
//   out_valid  out  inv_trans and clamped are valid
//   out_ready  in   downstream accepts the result
//   inv_trans  out  [15:0] 1/t, unsigned Q2.14, saturated to 65535
//   clamped    out  trans_in was forced to the nearest bound of [T_MIN, 32768]
//
// state | meaning
// IDLE  | waiting for a sample, in_ready=1
// DIV   | resolving one quotient bit per cycle, ITER cycles
// DONE  | result presented, held until out_ready

module inv_trans_divider #(
  parameter int T_MIN = 8192,
  parameter int ITER  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] trans_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] inv_trans,
  output logic        clamped
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] T_MIN_W  = 16'(T_MIN);
  localparam logic [15:0] T_ONE    = 16'd32768;
  localparam logic [29:0] DIV_BASE = 30'h2000_0000;
  localparam int          CNT_W    = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t           state;
  logic [15:0]      divisor;
  // The stored remainder is always < divisor <= 32768, so 16 bits hold it;
  // the shifted partial remainder below carries the 17th bit.
  logic [15:0]      remainder;
  logic [29:0]      dividend;
  logic [29:0]      quotient;
  logic [CNT_W-1:0] count;
  logic             clamp_lat;

  logic [15:0] d_clamp;
  logic        clamp_flag;
  logic [29:0] div_init;
  logic [16:0] rem_shift;
  logic        rem_ge;
  logic [15:0] rem_next;
  logic [29:0] quot_next;
  logic [15:0] quot_sat;

  always_comb begin
    d_clamp    = trans_in;
    clamp_flag = 1'b0;
    if (trans_in < T_MIN_W) begin
      d_clamp    = T_MIN_W;
      clamp_flag = 1'b1;
    end else if (trans_in > T_ONE) begin
      d_clamp    = T_ONE;
      clamp_flag = 1'b1;
    end
  end

`ifdef INV_TRANS_ROUND_EN
  // Adding half the divisor before the floor division rounds to nearest.
  assign div_init = DIV_BASE + 30'(d_clamp >> 1);
`else
  assign div_init = DIV_BASE;
`endif

  assign rem_shift = {remainder, dividend[29]};
  assign rem_ge    = (rem_shift >= {1'b0, divisor});
  // Either branch is < divisor, so the result always fits in 16 bits.
  assign rem_next  = rem_ge ? 16'(rem_shift - {1'b0, divisor}) : rem_shift[15:0];
  assign quot_next = {quotient[28:0], rem_ge};
  assign quot_sat  = (|quot_next[29:16]) ? 16'hFFFF : quot_next[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      inv_trans <= '0;
      clamped   <= 1'b0;
      divisor   <= '0;
      remainder <= '0;
      dividend  <= '0;
      quotient  <= '0;
      count     <= '0;
      clamp_lat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            divisor   <= d_clamp;
            clamp_lat <= clamp_flag;
            dividend  <= div_init;
            remainder <= '0;
            quotient  <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            state     <= DIV;
          end
        end
        DIV: begin
          dividend  <= {dividend[28:0], 1'b0};
          remainder <= rem_next;
          quotient  <= quot_next;
          count     <= count + 1'b1;
          if (count == CNT_LAST) begin
            inv_trans <= quot_sat;
            clamped   <= clamp_lat;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_trans_divider.sv
// Testbench for inv_trans_divider: directed boundary samples plus randomized
// samples with random backpressure, compared against an arithmetic model.

module tb_inv_trans_divider;

  localparam int T_MIN = 8192;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] trans_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] inv_trans;
  logic        clamped;

  int checks   = 0;
  int failures = 0;

  inv_trans_divider #(.T_MIN(T_MIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .trans_in  (trans_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inv_trans (inv_trans),
    .clamped   (clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_inv(input longint t);
    longint d, n, q;
    d = (t < T_MIN) ? T_MIN : ((t > 32768) ? 32768 : t);
    n = longint'(1) << 29;
`ifdef INV_TRANS_ROUND_EN
    n = n + d / 2;
`endif
    q = n / d;
    return (q > 65535) ? 65535 : q;
  endfunction

  function automatic longint model_clamp(input longint t);
    return (t < T_MIN || t > 32768) ? 1 : 0;
  endfunction

  // Drives one sample; checks latency, result, stability under stall and
  // the return of in_ready after the output handshake.
  task automatic run_txn(input logic [15:0] t, input int stall);
    int     k;
    longint exp_q, exp_c;
    exp_q = model_inv(t);
    exp_c = model_clamp(t);
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_val("in_ready_wait", longint'(in_ready), 1);
    in_valid  = 1'b1;
    trans_in  = t;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_val("latency", k, 30);
    check_val("inv_trans", longint'(inv_trans), exp_q);
    check_val("clamped", longint'(clamped), exp_c);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      trans_in = 16'd16384;
      @(negedge clk);
      check_val("stall_valid", longint'(out_valid), 1);
      check_val("stall_ready", longint'(in_ready), 0);
      check_val("stall_inv", longint'(inv_trans), exp_q);
      check_val("stall_clamp", longint'(clamped), exp_c);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("post_in_ready", longint'(in_ready), 1);
    check_val("post_out_valid", longint'(out_valid), 0);
  endtask

  initial begin
    int          seen;
    logic [15:0] directed [10];
    logic [15:0] t;
    directed = '{16'd32768, 16'd16384, 16'd8192, 16'd24576, 16'd0,
                 16'd40000, 16'd12288, 16'd8191, 16'd32769, 16'd65535};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    trans_in  = '0;
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", longint'(in_ready), 1);
    check_val("rst_out_valid", longint'(out_valid), 0);
    check_val("rst_inv", longint'(inv_trans), 0);
    check_val("rst_clamped", longint'(clamped), 0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(16'd32768, 0);
    check_val("one_exact", longint'(inv_trans), 16384);
    run_txn(16'd8192, 10);
    check_val("sat_value", longint'(inv_trans), 65535);
    check_val("sat_no_clamp", longint'(clamped), 0);

    foreach (directed[i]) run_txn(directed[i], i % 3);

    // Reset in the middle of the division aborts the sample.
    in_valid = 1'b1;
    trans_in = 16'd16384;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_in_ready", longint'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("abort_no_output", seen, 0);
    run_txn(16'd32768, 0);
    check_val("after_abort", longint'(inv_trans), 16384);

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0:       t = 16'($urandom_range(0, 65535));
        1:       t = 16'($urandom_range(T_MIN - 4, T_MIN + 4));
        2:       t = 16'($urandom_range(32764, 32772));
        default: t = 16'($urandom_range(T_MIN, 32768));
      endcase
      run_txn(t, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
